wrr_burst_arb: RTL

// - Weighted round-robin burst arbiter sharing one downstream resource among NUM_INPUTS requesters.
// - Grant is held for up to a per-requester quota of bursts, each closed by i_done; pointer then advances.
// - Sits in front of the shared datapath, upstream of the existing rr_arb-style single-cycle grant path.

---
 rtl/wrr_burst_arb.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wrr_burst_arb.sv
`default_nettype none
// ============================================================================
// Module      : wrr_burst_arb
// Description : Weighted round-robin burst arbiter; optional forced-release
//               timeout enabled by defining WRR_ARB_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module wrr_burst_arb #(
   parameter int NUM_INPUTS  = 8,
   parameter int WEIGHT_W    = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_INPUTS-1:0]            i_grant,
   input  logic                             i_valid,
   input  logic [NUM_INPUTS*WEIGHT_W-1:0]   i_weight,
   input  logic                             i_done,
   output logic [NUM_INPUTS-1:0]            o_grant,
   output logic                             o_valid,
   output logic [$clog2(NUM_INPUTS)-1:0]    o_gnt_id,
   output logic                             o_timeout
);

   localparam int c_ID_W = $clog2(NUM_INPUTS);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t                r_state,   w_state_nxt;
   logic [NUM_INPUTS-1:0] r_grant,   w_grant_nxt;
   logic                  r_valid,   w_valid_nxt;
   logic [c_ID_W-1:0]     r_gnt_id,  w_gnt_id_nxt;
   logic [c_ID_W-1:0]     r_ptr,     w_ptr_nxt;
   logic [WEIGHT_W-1:0]   r_quota,   w_quota_nxt;
   logic                  r_timeout, w_timeout_nxt;

   logic [WEIGHT_W-1:0]   w_wt_arr [NUM_INPUTS];
   logic [c_ID_W-1:0]     w_adv_ptr;
   logic [c_ID_W-1:0]     w_sel_ptr;
   logic [c_ID_W:0]       w_pick;
   logic                  w_found;
   logic [c_ID_W-1:0]     w_pick_idx;
   logic [WEIGHT_W-1:0]   w_pick_wt;
   logic [WEIGHT_W-1:0]   w_load_quota;
   logic                  w_tmo_fire;
   logic                  w_release;
   logic                  w_load;
   logic                  w_clear;

   // Circular first-set search starting at 'start'; returns {found, index}.
   function automatic logic [c_ID_W:0] f_pick(input logic [NUM_INPUTS-1:0] req,
                                              input logic [c_ID_W-1:0]     start);
      logic              found;
      logic [c_ID_W-1:0] idx;
      logic [c_ID_W-1:0] kk;
      int                k;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         k = int'(start) + i;
         if (k >= NUM_INPUTS) begin
            k = k - NUM_INPUTS;
         end
         kk = c_ID_W'(k);
         if (!found && req[kk]) begin
            found = 1'b1;
            idx   = kk;
         end
      end
      return {found, idx};
   endfunction

   generate
      for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_wt
         assign w_wt_arr[n] = i_weight[n*WEIGHT_W +: WEIGHT_W];
      end
   endgenerate

   assign w_adv_ptr    = (r_gnt_id == c_ID_W'(NUM_INPUTS-1)) ? '0 : r_gnt_id + 1'b1;
   // In GRANT the only selection that matters is the one after a release.
   assign w_sel_ptr    = (r_state == S_GRANT) ? w_adv_ptr : r_ptr;
   assign w_pick       = f_pick(i_grant, w_sel_ptr);
   assign w_found      = w_pick[c_ID_W];
   assign w_pick_idx   = w_pick[c_ID_W-1:0];
   assign w_pick_wt    = w_wt_arr[w_pick_idx];
   assign w_load_quota = (w_pick_wt == '0) ? WEIGHT_W'(1) : w_pick_wt;

`ifdef WRR_ARB_TIMEOUT_EN
   localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [c_TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;

   assign w_tmo_fire = (r_state == S_GRANT) && !i_done &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (TIMEOUT_CYC > 0);
   assign w_tmo_fire   = 1'b0;
`endif

   assign w_release = (i_done && (r_quota == WEIGHT_W'(1))) ||
                      !i_grant[r_gnt_id] || w_tmo_fire;

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_valid_nxt   = r_valid;
      w_gnt_id_nxt  = r_gnt_id;
      w_ptr_nxt     = r_ptr;
      w_quota_nxt   = r_quota;
      w_timeout_nxt = 1'b0;
      w_load        = 1'b0;
      w_clear       = 1'b0;
`ifdef WRR_ARB_TIMEOUT_EN
      w_tmo_nxt     = r_tmo_cnt;
`endif

      case (r_state)
         S_IDLE: begin
            if (i_valid && (|i_grant)) begin
               w_load = 1'b1;
            end
         end
         S_GRANT: begin
            if (!i_valid) begin
               w_clear   = 1'b1;
               w_ptr_nxt = w_adv_ptr;
            end else if (w_release) begin
               w_ptr_nxt     = w_adv_ptr;
               w_timeout_nxt = w_tmo_fire;
               if (w_found) begin
                  w_load = 1'b1;
               end else begin
                  w_clear = 1'b1;
               end
            end else if (i_done) begin
               w_quota_nxt = r_quota - 1'b1;
`ifdef WRR_ARB_TIMEOUT_EN
               w_tmo_nxt   = '0;
`endif
            end else begin
`ifdef WRR_ARB_TIMEOUT_EN
               w_tmo_nxt   = r_tmo_cnt + 1'b1;
`endif
            end
         end
         default: begin
            w_clear = 1'b1;
         end
      endcase

      if (w_load) begin
         w_state_nxt  = S_GRANT;
         w_grant_nxt  = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << w_pick_idx;
         w_valid_nxt  = 1'b1;
         w_gnt_id_nxt = w_pick_idx;
         w_quota_nxt  = w_load_quota;
`ifdef WRR_ARB_TIMEOUT_EN
         w_tmo_nxt    = '0;
`endif
      end else if (w_clear) begin
         w_state_nxt  = S_IDLE;
         w_grant_nxt  = '0;
         w_valid_nxt  = 1'b0;
         w_gnt_id_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_valid   <= 1'b0;
         r_gnt_id  <= '0;
         r_ptr     <= '0;
         r_quota   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_valid   <= w_valid_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_ptr     <= w_ptr_nxt;
         r_quota   <= w_quota_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

`ifdef WRR_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= w_tmo_nxt;
      end
   end
`endif

   assign o_grant   = r_grant;
   assign o_valid   = r_valid;
   assign o_gnt_id  = r_gnt_id;
   assign o_timeout = r_timeout;

endmodule
`default_nettype wire
